// File: rtl/button_conditioner_if.sv
// Raw push-button inputs and conditioned level/pulse outputs of button_conditioner.
// master drives the raw buttons and observes the outputs; slave is the conditioner.
interface button_conditioner_if;
    logic up_button_raw;
    logic down_button_raw;
    logic center_button_raw;
    logic up_button_level;
    logic down_button_level;
    logic center_button_level;
    logic up_button_pulse;
    logic down_button_pulse;
    logic center_button_pulse;

    modport master (
        output up_button_raw, down_button_raw, center_button_raw,
        input  up_button_level, down_button_level, center_button_level,
        input  up_button_pulse, down_button_pulse, center_button_pulse
    );

    modport slave (
        input  up_button_raw, down_button_raw, center_button_raw,
        output up_button_level, down_button_level, center_button_level,
        output up_button_pulse, down_button_pulse, center_button_pulse
    );
endinterface

// File: rtl/button_conditioner.sv
// Synchronize, debounce and edge-detect the up/down/center push-buttons (channel 0/1/2).
// Optional macro BUTTON_CONDITIONER_AUTO_REPEAT_EN adds hold-to-repeat pulses on up/down.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 15000000
) (
    input logic               clk,
    input logic               rst,
    button_conditioner_if.slave btn
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("button_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic [2:0]    raw;
    logic [2:0]    s1_q, s1_d;
    logic [2:0]    s2_q, s2_d;
    logic [2:0]    level_q, level_d;
    logic [2:0]    pulse_q, pulse_d;
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];

    assign raw = {btn.center_button_raw, btn.down_button_raw, btn.up_button_raw};

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    localparam int            RW         = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
    localparam logic [RW-1:0] REP_FIRST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] REP_NEXT   = RW'(REPEAT_DELAY + REPEAT_PERIOD - 1);
    localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY);

    logic [RW-1:0] rep_q [2];
    logic [RW-1:0] rep_d [2];
`endif

    always_comb begin
        s1_d = raw;
        s2_d = s1_q;
        for (int i = 0; i < 3; i++) begin
            level_d[i] = level_q[i];
            pulse_d[i] = 1'b0;
            cnt_d[i]   = '0;
            // Any sample agreeing with the current level leaves the counter at zero.
            if (s2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = ~level_q[i];
                    pulse_d[i] = ~level_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
        // Repeat counter runs only while the level stays high; it wraps back to
        // REPEAT_DELAY after each periodic pulse so it never exceeds its range.
        for (int j = 0; j < 2; j++) begin
            rep_d[j] = '0;
            if (level_q[j] && level_d[j]) begin
                if (rep_q[j] == REP_FIRST || rep_q[j] == REP_NEXT) begin
                    pulse_d[j] = 1'b1;
                end
                rep_d[j] = (rep_q[j] == REP_NEXT) ? REP_RELOAD : rep_q[j] + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            level_q <= '0;
            pulse_q <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
            for (int j = 0; j < 2; j++) begin
                rep_q[j] <= '0;
            end
`endif
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
            for (int j = 0; j < 2; j++) begin
                rep_q[j] <= rep_d[j];
            end
`endif
        end
    end

    assign btn.up_button_level     = level_q[0];
    assign btn.down_button_level   = level_q[1];
    assign btn.center_button_level = level_q[2];
    assign btn.up_button_pulse     = pulse_q[0];
    assign btn.down_button_pulse   = pulse_q[1];
    assign btn.center_button_pulse = pulse_q[2];

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: window-based reference model checked every cycle,
// directed scenarios with literal timing expectations, then randomized buttons/resets.
module tb_button_conditioner;

    localparam int D    = 4;
    localparam int RD   = 10;
    localparam int RP   = 3;
    localparam int NMAX = 8192;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    button_conditioner_if bus ();

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn(bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: history of sampled inputs per rising edge, plus expected outputs.
    logic [2:0] raw_h [NMAX];
    logic       rst_h [NMAX];
    int         n        = -1;
    logic [2:0] exp_lvl  = '0;
    logic [2:0] exp_pls  = '0;
    int         rise_e [3];
    bit         model_ok = 1'b0;

    // Value the debouncer sees at edge k: the raw button two edges earlier,
    // or zero while the synchronizer is still flushing out of reset.
    function automatic logic samp(input int k, input int ch);
        if (k < 2) return 1'b0;
        if (rst_h[k-1] || rst_h[k-2]) return 1'b0;
        return raw_h[k-2][ch];
    endfunction

    always @(posedge clk) begin
        bit flip;
        n = n + 1;
        if (n >= NMAX) begin
            $display("FAIL model_range edge %0d exceeds history %0d", n, NMAX);
            $fatal(1, "history overflow");
        end
        raw_h[n] = {bus.center_button_raw, bus.down_button_raw, bus.up_button_raw};
        rst_h[n] = rst;
        for (int ch = 0; ch < 3; ch++) begin
            if (rst) begin
                exp_lvl[ch] = 1'b0;
                exp_pls[ch] = 1'b0;
            end else begin
                // Level flips once the last D samples all disagree with it.
                flip = 1'b1;
                for (int k = n - D + 1; k <= n; k++) begin
                    if (k < 0) flip = 1'b0;
                    else if (rst_h[k] || samp(k, ch) == exp_lvl[ch]) flip = 1'b0;
                end
                exp_pls[ch] = 1'b0;
                if (flip) begin
                    exp_lvl[ch] = ~exp_lvl[ch];
                    if (exp_lvl[ch]) begin
                        exp_pls[ch] = 1'b1;
                        rise_e[ch]  = n;
                    end
                end
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
                else if (ch < 2 && exp_lvl[ch]) begin
                    int t;
                    t = n - rise_e[ch];
                    if (t == RD || (t > RD && (t - RD) % RP == 0)) exp_pls[ch] = 1'b1;
                end
`endif
            end
        end
        model_ok = 1'b1;
    end

    function automatic logic [2:0] dut_lvl();
        return {bus.center_button_level, bus.down_button_level, bus.up_button_level};
    endfunction

    function automatic logic [2:0] dut_pls();
        return {bus.center_button_pulse, bus.down_button_pulse, bus.up_button_pulse};
    endfunction

    always @(negedge clk) begin
        if (model_ok) begin
            vectors = vectors + 1;
            if ({dut_pls(), dut_lvl()} !== {exp_pls, exp_lvl}) begin
                miscompares = miscompares + 1;
                $display("FAIL cycle_check edge %0d: got pls/lvl %b/%b, required %b/%b",
                         n, dut_pls(), dut_lvl(), exp_pls, exp_lvl);
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        vectors = vectors + 1;
        if (got != want) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic drive(input logic [2:0] r, input logic rs);
        @(negedge clk);
        {bus.center_button_raw, bus.down_button_raw, bus.up_button_raw} = r;
        rst = rs;
    endtask

    // Observe ncyc cycles with inputs frozen; index 0 is the cycle after the
    // first rising edge following the last drive.
    int w_first [3];
    int w_cnt   [3];
    int w_chg   [3];
    int up_times [$];

    task automatic watch(input int ncyc);
        logic [2:0] l0, p, l;
        l0 = dut_lvl();
        up_times.delete();
        for (int c = 0; c < 3; c++) begin
            w_first[c] = -1;
            w_cnt[c]   = 0;
            w_chg[c]   = -1;
        end
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            p = dut_pls();
            l = dut_lvl();
            for (int c = 0; c < 3; c++) begin
                if (p[c]) begin
                    if (w_first[c] < 0) w_first[c] = i;
                    w_cnt[c] = w_cnt[c] + 1;
                    if (c == 0) up_times.push_back(i);
                end
                if (l[c] != l0[c] && w_chg[c] < 0) w_chg[c] = i;
            end
        end
    endtask

    initial begin
        {bus.center_button_raw, bus.down_button_raw, bus.up_button_raw} = 3'b000;
        drive(3'b000, 1'b1);
        drive(3'b000, 1'b1);

        // Clean press of up
        drive(3'b001, 1'b0);
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
        watch(24);
        check("press_first_pulse", w_first[0], 5);
        check("press_level_rise", w_chg[0], 5);
        check("repeat_count", w_cnt[0], 4);
        if (up_times.size() == 4) begin
            check("repeat_gap1", up_times[1] - up_times[0], RD);
            check("repeat_gap2", up_times[2] - up_times[0], RD + RP);
            check("repeat_gap3", up_times[3] - up_times[0], RD + 2 * RP);
        end
`else
        watch(12);
        check("press_first_pulse", w_first[0], 5);
        check("press_level_rise", w_chg[0], 5);
        check("press_pulse_count", w_cnt[0], 1);
        watch(60);
        check("long_hold_extra_pulses", w_cnt[0], 0);
`endif
        check("press_down_quiet", w_cnt[1] + w_cnt[2], 0);

        // Release of up
        drive(3'b000, 1'b0);
        watch(12);
        check("release_level_fall", w_chg[0], 5);
`ifndef BUTTON_CONDITIONER_AUTO_REPEAT_EN
        check("release_no_pulse", w_cnt[0], 0);
`endif

        // Bounce on center, then a real hold
        drive(3'b100, 1'b0);
        drive(3'b000, 1'b0);
        drive(3'b100, 1'b0);
        drive(3'b000, 1'b0);
        watch(15);
        check("bounce_no_pulse", w_cnt[2], 0);
        check("bounce_no_level", w_chg[2], -1);
        drive(3'b100, 1'b0);
        watch(30);
        check("center_first_pulse", w_first[2], 5);
        check("center_hold_one_pulse", w_cnt[2], 1);
        drive(3'b000, 1'b0);
        watch(10);

        // Simultaneous up and down
        drive(3'b011, 1'b0);
        watch(12);
        check("simul_up_first", w_first[0], 5);
        check("simul_down_first", w_first[1], 5);
        check("simul_up_count", w_cnt[0], 1);
        check("simul_down_count", w_cnt[1], 1);

        // Reset while down is held with level high
        drive(3'b010, 1'b0);
        watch(10);
        drive(3'b010, 1'b1);
        @(negedge clk);
        check("reset_clears_outputs", int'({dut_pls(), dut_lvl()}), 0);
        rst = 1'b0;
        watch(12);
        check("reset_repress_first", w_first[1], 5);
        check("reset_repress_count", w_cnt[1], 1);
        drive(3'b000, 1'b0);
        watch(10);

        // Randomized buttons with occasional resets
        for (int i = 0; i < 2500; i++) begin
            logic [2:0] r;
            r = {bus.center_button_raw, bus.down_button_raw, bus.up_button_raw};
            for (int c = 0; c < 3; c++) begin
                if ($urandom_range(0, 9) == 0) r[c] = ~r[c];
            end
            drive(r, ($urandom_range(0, 299) == 0));
        end
        drive(3'b000, 1'b0);
        watch(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream front end for the answer-selection stage.
- Takes the three raw board push-buttons (up, down, center) and synchronizes each to clk, then debounces each one.
- Emits one single-cycle press pulse per physical press, plus a debounced level per button.
- The pulses drive the up/down/center button inputs of the answer-selector code generator, so one press moves the selection exactly one step.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized samples required to accept a level change (10 ms at 100 MHz); must be >= 1.
- REPEAT_DELAY, 50000000, cycles a held up/down button must stay pressed before the first auto-repeat pulse (AUTO_REPEAT_EN only).
- REPEAT_PERIOD, 15000000, cycles between subsequent auto-repeat pulses (AUTO_REPEAT_EN only).

Ports:
- clk  input  1  system clock, all logic rising-edge
- rst  input  1  synchronous reset, active-high
- up_button_raw  input  1  asynchronous, bouncy up button
- down_button_raw  input  1  asynchronous, bouncy down button
- center_button_raw  input  1  asynchronous, bouncy center button
- up_button_level  output  1  debounced level, up
- down_button_level  output  1  debounced level, down
- center_button_level  output  1  debounced level, center
- up_button_pulse  output  1  one-cycle press pulse, up
- down_button_pulse  output  1  one-cycle press pulse, down
- center_button_pulse  output  1  one-cycle press pulse, center

Behaviour:
- One clock (clk); reset is synchronous, active-high (rst). Sampled only on the rising edge of clk; takes priority over all other logic.
- Reset state: all synchronizer flops, debounce counters, repeat counters and outputs are 0.
- Per button, three identical independent channels; no priority or mutual exclusion between buttons.
- Synchronizer: 2-flop chain raw -> s1 -> s2. Only s2 is used downstream.
- Debounce counter:
  - width $clog2(DEBOUNCE_CYCLES+1).
  - If s2 == level, clear it.
  - If s2 != level, increment it.
  - When the increment would reach DEBOUNCE_CYCLES, invert level and clear the counter in the same edge.
  - Any sample matching level before that point restarts the count (glitch rejection).
- Pulse:
  - Registered; asserted for exactly the one cycle following the edge on which level goes 0 -> 1.
  - No pulse on the 1 -> 0 transition.
- Latency: raw input held constant from edge 0 gives a level change and pulse visible after edge DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 edges including the capture edge.
- Counters saturate by construction and never wrap. A continuous hold gives exactly one pulse.
- Simultaneous presses: each channel pulses independently; two or three pulses may be high in the same cycle.
- Reset mid-operation: all state clears. If a button is still held at reset release, level starts at 0 and a normal press pulse follows DEBOUNCE_CYCLES+2 edges later.
- Reset asserted during a pulse cycle: the pulse drops on that edge.

Optional Feature:
- Macro: BUTTON_CONDITIONER_AUTO_REPEAT_EN.
- Defined:
  - up and down channels each get a repeat counter. It is cleared whenever level == 0 and counts while level == 1.
  - First extra pulse is on the cycle after level has been 1 for REPEAT_DELAY cycles.
  - Further pulses follow every REPEAT_PERIOD cycles while held.
  - Release clears the counter immediately, with no pulse on release.
  - Center never auto-repeats.
- Undefined: no repeat counters are synthesized, REPEAT_* are ignored, and every press yields exactly one pulse.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3):
- Clean press: rst 1 for 2 cycles, then up_button_raw 0 -> 1 held at edge 0 -> up_button_level and up_button_pulse rise after edge 5; pulse is 1 for exactly one cycle; down/center outputs stay 0.
- Bounce rejection: center_button_raw toggles 1,0,1,0 on consecutive cycles, then stays 0 -> center_button_level and center_button_pulse never assert. Then held 1 -> single pulse 6 edges after the final rise.
- Release: after a debounced up press, raw drops to 0 -> level falls 6 edges later; no pulse on release; long hold gives exactly 1 pulse total (macro off).
- Simultaneous: up and down raw rise on the same edge -> up_button_pulse and down_button_pulse both high in the same single cycle.
- Reset mid-press: rst pulsed for 1 cycle while down held with level=1 -> all outputs 0 on the following cycle; down_button_pulse fires again 6 edges after rst deasserts.
- Auto-repeat (macro defined): up held -> initial pulse, then pulses 10, 13 and 16 cycles after the initial pulse. Center held for 30 cycles -> exactly 1 pulse.
